// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO controller: register addresses and default sizing.
package gpio_pkg;

  localparam int GPIO_WIDTH_DEFAULT       = 32;
  localparam int GPIO_SYNC_STAGES_DEFAULT = 2;

  localparam logic [2:0] ADDR_OUT     = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IN      = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;
  localparam logic [2:0] ADDR_SET     = 3'd6;
  localparam logic [2:0] ADDR_CLR     = 3'd7;

endpackage

// File: rtl/gpio_sync.sv
// Multi-flop synchronizer bringing asynchronous pad inputs into the clk domain.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_p;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: output/direction registers, synchronized inputs, per-bit
// rise/fall edge detection with sticky status and a registered interrupt.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH       = GPIO_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = GPIO_SYNC_STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic [2:0]       addr,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] in_p0;
  logic [WIDTH-1:0] in_p1;
  logic [WIDTH-1:0] status_set;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] rd_mux;

  function automatic logic [WIDTH-1:0] edge_hits(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] prev,
    input logic [WIDTH-1:0] ren,
    input logic [WIDTH-1:0] fen
  );
    return ((cur & ~prev) & ren) | ((~cur & prev) & fen);
  endfunction

  gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .Rst_n(Rst_n),
    .d    (pin_in),
    .q    (in_p0)
  );

  always_comb begin
    status_set = edge_hits(in_p0, in_p1, rise_en_q, fall_en_q);
    status_clr = (wr_en && addr == ADDR_STATUS) ? wdata : '0;
    rd_mux     = '0;
    case (addr)
      ADDR_OUT:     rd_mux = out_q;
      ADDR_DIR:     rd_mux = dir_q;
      ADDR_IN:      rd_mux = in_p0;
      ADDR_RISE_EN: rd_mux = rise_en_q;
      ADDR_FALL_EN: rd_mux = fall_en_q;
      ADDR_STATUS:  rd_mux = status_q;
      default:      rd_mux = '0;
    endcase
  end

  // Software-visible control registers; write to IN is silently dropped.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_OUT:     out_q     <= wdata;
        ADDR_DIR:     dir_q     <= wdata;
        ADDR_RISE_EN: rise_en_q <= wdata;
        ADDR_FALL_EN: fall_en_q <= wdata;
        ADDR_SET:     out_q     <= out_q | wdata;
        ADDR_CLR:     out_q     <= out_q & ~wdata;
        default:      ;
      endcase
    end
  end

  // Stage p1: delayed input copy, sticky status (set beats clear), irq, read data.
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      in_p1    <= '0;
      status_q <= '0;
      irq      <= 1'b0;
      rdata    <= '0;
    end else begin
      in_p1    <= in_p0;
      status_q <= (status_q & ~status_clr) | status_set;
      irq      <= |status_q;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

  assign pin_out = out_q;
  assign pin_oe  = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Randomized + directed bench for gpio_ctrl with a queue-based scoreboard.
module tb_gpio_ctrl;

  localparam logic [2:0] A_OUT = 3'd0, A_DIR = 3'd1, A_IN = 3'd2, A_REN = 3'd3;
  localparam logic [2:0] A_FEN = 3'd4, A_STS = 3'd5, A_SET = 3'd6, A_CLR = 3'd7;

  logic       clk;
  logic       Rst_n;
  logic [2:0] addr;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] pin_in;
  logic [7:0] pin_out;
  logic [7:0] pin_oe;
  logic       irq;

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .Rst_n  (Rst_n),
    .addr   (addr),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wdata  (wdata),
    .rdata  (rdata),
    .pin_in (pin_in),
    .pin_out(pin_out),
    .pin_oe (pin_oe),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rdata;
    logic [7:0] pout;
    logic [7:0] poe;
    logic       irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Behavioural model state
  logic [7:0] m_out, m_dir, m_ren, m_fen, m_sts, m_in, m_prev, m_rdata;
  logic       m_irq;
  logic [7:0] m_dly[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_out = 0; m_dir = 0; m_ren = 0; m_fen = 0; m_sts = 0;
    m_in = 0; m_prev = 0; m_rdata = 0; m_irq = 0;
    m_dly.delete();
    m_dly.push_back(8'h00);
  endfunction

  function automatic void model_edge(input logic wr, input logic rd, input logic [2:0] a,
                                     input logic [7:0] wd, input logic [7:0] pin);
    logic [7:0] rv, hits, clr;
    exp_t e;
    case (a)
      A_OUT: rv = m_out;
      A_DIR: rv = m_dir;
      A_IN:  rv = m_in;
      A_REN: rv = m_ren;
      A_FEN: rv = m_fen;
      A_STS: rv = m_sts;
      default: rv = 8'h00;
    endcase
    hits = ((m_in & ~m_prev) & m_ren) | ((~m_in & m_prev) & m_fen);
    clr  = (wr && a == A_STS) ? wd : 8'h00;
    m_irq = (m_sts != 0);
    m_sts = (m_sts & ~clr) | hits;
    if (rd) m_rdata = rv;
    if (wr) begin
      case (a)
        A_OUT: m_out = wd;
        A_DIR: m_dir = wd;
        A_REN: m_ren = wd;
        A_FEN: m_fen = wd;
        A_SET: m_out = m_out | wd;
        A_CLR: m_out = m_out & ~wd;
        default: ;
      endcase
    end
    m_prev = m_in;
    m_dly.push_back(pin);
    m_in = m_dly.pop_front();
    e.rdata = m_rdata; e.pout = m_out; e.poe = m_dir; e.irq = m_irq;
    exp_q.push_back(e);
  endfunction

  task automatic cycle(input logic wr, input logic rd, input logic [2:0] a, input logic [7:0] wd);
    wr_en = wr; rd_en = rd; addr = a; wdata = wd;
    @(posedge clk);
    model_edge(wr, rd, a, wd, pin_in);
    #2;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, A_OUT, 8'h00);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("rdata",   rdata,   e.rdata);
      check("pin_out", pin_out, e.pout);
      check("pin_oe",  pin_oe,  e.poe);
      check("irq",     irq,     e.irq);
    end
  end

  initial begin
    Rst_n = 1'b0; addr = 0; wr_en = 0; rd_en = 0; wdata = 0; pin_in = 0;
    model_reset();
    #1;
    check("reset_pin_out", pin_out, 8'h00);
    check("reset_pin_oe",  pin_oe,  8'h00);
    check("reset_rdata",   rdata,   8'h00);
    check("reset_irq",     irq,     1'b0);
    @(posedge clk); @(posedge clk); #2;
    Rst_n = 1'b1;

    // Direction and output registers with readback
    cycle(1, 0, A_DIR, 8'h0F);
    cycle(1, 0, A_OUT, 8'hA5);
    check("dir_pin_oe", pin_oe, 8'h0F);
    check("out_pin_out", pin_out, 8'hA5);
    cycle(0, 1, A_OUT, 8'h00);
    check("rd_out", rdata, 8'hA5);
    cycle(0, 1, A_DIR, 8'h00);
    check("rd_dir", rdata, 8'h0F);
    cycle(0, 1, A_SET, 8'h00);
    check("rd_set_zero", rdata, 8'h00);
    cycle(1, 0, A_IN, 8'hFF);

    // Atomic set/clear
    cycle(1, 0, A_SET, 8'h0A);
    check("set_out", pin_out, 8'hAF);
    cycle(1, 0, A_CLR, 8'h81);
    check("clr_out", pin_out, 8'h2E);

    // Rise on bit 0: IN after edge 2, STATUS after edge 3, irq after edge 4
    cycle(1, 0, A_REN, 8'h01);
    pin_in = 8'h01;
    idle(2);
    check("rise_irq_e2", irq, 1'b0);
    cycle(0, 1, A_IN, 8'h00);
    check("rise_in_e3", rdata, 8'h01);
    check("rise_irq_e3", irq, 1'b0);
    cycle(0, 1, A_STS, 8'h00);
    check("rise_sts_e4", rdata, 8'h01);
    check("rise_irq_e4", irq, 1'b1);
    cycle(1, 0, A_STS, 8'hFF);
    idle(1);
    check("w1c_irq", irq, 1'b0);

    // Fall enabled on bit 7 only
    pin_in = 8'hC1;
    idle(4);
    cycle(1, 0, A_FEN, 8'h80);
    pin_in = 8'h01;
    idle(4);
    cycle(0, 1, A_STS, 8'h00);
    check("fall_sts", rdata, 8'h80);
    check("fall_irq", irq, 1'b1);
    cycle(1, 0, A_STS, 8'h80);
    cycle(0, 1, A_STS, 8'h00);
    check("fall_clr_sts", rdata, 8'h00);
    check("fall_clr_irq", irq, 1'b0);

    // Set beats clear on the same bit in the same cycle
    pin_in = 8'h00; idle(3);
    pin_in = 8'h01; idle(4);
    check("sw_pre_irq", irq, 1'b1);
    pin_in = 8'h00; idle(3);
    pin_in = 8'h01;
    idle(2);
    cycle(1, 0, A_STS, 8'h01);
    cycle(0, 1, A_STS, 8'h00);
    check("setwins_sts", rdata, 8'h01);
    check("setwins_irq", irq, 1'b1);

    // Reset mid-operation
    cycle(1, 0, A_OUT, 8'hFF);
    cycle(1, 0, A_REN, 8'h03);
    cycle(1, 0, A_STS, 8'hFF);
    pin_in = 8'h00; idle(3);
    pin_in = 8'h03; idle(4);
    cycle(0, 1, A_STS, 8'h00);
    check("pre_rst_sts", rdata, 8'h03);
    @(negedge clk); #1;
    wr_en = 1'b1; addr = A_DIR; wdata = 8'hF0;
    Rst_n = 1'b0;
    pin_in = 8'hFF;
    #1;
    check("arst_pin_out", pin_out, 8'h00);
    check("arst_pin_oe",  pin_oe,  8'h00);
    check("arst_rdata",   rdata,   8'h00);
    check("arst_irq",     irq,     1'b0);
    @(posedge clk); @(posedge clk); #2;
    wr_en = 1'b0;
    Rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) cycle(0, 1, A_STS, 8'h00);
    check("post_rst_sts", rdata, 8'h00);
    check("post_rst_irq", irq, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) pin_in = 8'($urandom);
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 8'($urandom));
    end

    @(negedge clk); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: number of GPIO bits and data-bus width (legal 1..32).
REQ-002 Parameter SYNC_STAGES, default 2: input synchronizer depth (legal 2..4).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port addr  input  3  register select (map in REQ-011).
REQ-006 Port wr_en  input  1  write strobe, one write per asserted cycle.
REQ-007 Port rd_en  input  1  read strobe.
REQ-008 Port wdata  input  WIDTH  write data.
REQ-009 Port rdata  output  WIDTH  registered read data.
REQ-010 Ports pin_in  input  WIDTH  pad input, asynchronous; pin_out  output  WIDTH  pad drive value; pin_oe  output  WIDTH  pad output enable (1 = drive); irq  output  1  registered interrupt.

Function
REQ-011 Register map: 0 OUT (RW), 1 DIR (RW, 1 = output), 2 IN (RO, synchronized pins), 3 RISE_EN (RW), 4 FALL_EN (RW), 5 STATUS (R, write-1-to-clear), 6 SET (WO, OUT |= wdata), 7 CLR (WO, OUT &= ~wdata).
REQ-012 pin_out = OUT and pin_oe = DIR, both driven directly from registers, zero added latency.
REQ-013 Write takes effect at the rising edge where wr_en = 1; written value is visible on pin_out/pin_oe after that edge.
REQ-014 Read: rd_en = 1 at edge k -> rdata holds addressed register value after edge k; rdata holds its value while rd_en = 0.
REQ-015 Reads of addresses 6 and 7 return 0; writes to address 2 are ignored.
REQ-016 Simultaneous wr_en and rd_en to the same address: rdata returns the pre-write value.
REQ-017 Each pin_in bit passes through a SYNC_STAGES-flop chain; IN = last stage; pin change stable before edge 1 is visible in IN after edge SYNC_STAGES.
REQ-018 Edge detect compares IN against a one-cycle-delayed copy (PREV): rise = IN & ~PREV, fall = ~IN & PREV, per bit.
REQ-019 STATUS[i] sets at the edge after the edge is detected if (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); sticky until cleared.
REQ-020 Edge detection applies to every bit regardless of DIR.
REQ-021 Write to STATUS clears bits where wdata = 1; if a set condition and a clear hit the same bit in the same cycle, set wins.
REQ-022 Disabling an enable bit does not clear an already-set STATUS bit.
REQ-023 irq = registered OR of STATUS; asserts one edge after the first STATUS bit sets, deasserts one edge after STATUS becomes all-zero.
REQ-024 End-to-end latency with SYNC_STAGES = 2: pin change before edge 1 -> IN after edge 2, STATUS after edge 3, irq after edge 4.

Reset
REQ-025 Rst_n low asynchronously clears OUT, DIR, RISE_EN, FALL_EN, STATUS, synchronizer chain, PREV, rdata and irq to 0.
REQ-026 After reset release, no STATUS bit sets until software sets an enable bit; edges from pins high at release are discarded because enables are 0.
REQ-027 Reset asserted mid-transaction aborts the write; no partial register update occurs.

Structure
REQ-028 Shared package gpio_pkg holds register-address constants (ADDR_OUT .. ADDR_CLR) and default WIDTH/SYNC_STAGES values.
REQ-029 Sub-module gpio_sync (WIDTH, SYNC_STAGES parameters, clk, Rst_n, d, q) implements the synchronizer chain; gpio_ctrl instantiates one.
REQ-030 No latches; all registers share clk and Rst_n.

Verification (WIDTH = 8, SYNC_STAGES = 2)
REQ-031 Write DIR = 0x0F, OUT = 0xA5 -> pin_oe = 0x0F, pin_out = 0xA5 after the write edge; readback of both matches.
REQ-032 Write SET = 0x0A after OUT = 0xA5 -> OUT = 0xAF; then CLR = 0x81 -> OUT = 0x2E.
REQ-033 RISE_EN = 0x01, pin_in[0] 0 -> 1 before edge 1 -> IN[0] = 1 after edge 2, STATUS = 0x01 after edge 3, irq = 1 after edge 4.
REQ-034 FALL_EN = 0x80, pin_in[7] 1 -> 0 and pin_in[6] 1 -> 0 -> STATUS = 0x80 only; write STATUS = 0x80 -> STATUS = 0, irq = 0 one edge later.
REQ-035 Write STATUS = 0x01 in the same cycle a new enabled rise on bit 0 is detected -> STATUS[0] remains 1, irq stays 1.
REQ-036 Rst_n low mid-operation with OUT = 0xFF, STATUS = 0x03 -> all outputs 0 immediately, irq = 0, no STATUS set after release with pin_in = 0xFF.
